// File: rtl/mips_cpu_alu_sequencer_if.sv
// Decode-to-ALU sequencer bundle: instruction handshake, ALU control/operands and the writeback/HI-LO view.
interface mips_cpu_alu_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_sa;
  logic [31:0] alu_r;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  dest_reg;
  logic        write_en;
  logic        illegal;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport slave (
    input  instr_valid, instr, rs_data, rt_data, alu_r,
    output instr_ready, alu_control, alu_a, alu_b, alu_sa,
           result_valid, result, dest_reg, write_en, illegal, hi, lo, busy
  );

  modport master (
    output instr_valid, instr, rs_data, rt_data, alu_r,
    input  instr_ready, alu_control, alu_a, alu_b, alu_sa,
           result_valid, result, dest_reg, write_en, illegal, hi, lo, busy
  );
endinterface

// File: rtl/mips_cpu_alu_sequencer.sv
// One-at-a-time issue controller in front of a registered ALU.
// It also owns HI/LO and runs an iterative shift-add multiplier and a restoring divider.
module mips_cpu_alu_sequencer #(
  parameter int ALU_LATENCY    = 1,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_cpu_alu_sequencer_if.slave     bus
);

  localparam int ITER = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] ITER_M1 = 6'(ITER - 1);
  localparam logic [5:0] LAT_M1  = 6'(ALU_LATENCY - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_MULDIV = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] C_ALU  = 3'd0;
  localparam logic [2:0] C_MFHI = 3'd1;
  localparam logic [2:0] C_MFLO = 3'd2;
  localparam logic [2:0] C_MTHI = 3'd3;
  localparam logic [2:0] C_MTLO = 3'd4;
  localparam logic [2:0] C_MUL  = 3'd5;
  localparam logic [2:0] C_DIV  = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  logic [2:0]  r_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_cls;
  logic [31:0] r_opa;
  logic [31:0] r_w_hi;
  logic [31:0] r_w_lo;
  logic [31:0] r_mcand;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div0;
  logic [4:0]  r_alu_control;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [5:0]  r_alu_sa;
  logic [31:0] r_result;
  logic [4:0]  r_dest;
  logic        r_we;
  logic        r_illegal;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;
  logic [2:0]  w_cls;
  logic [3:0]  w_ctrl;
  logic [31:0] w_b;
  logic [4:0]  w_dest;
  logic        w_wr;
  logic        w_sgn;
  logic        w_we;
  logic        w_accept;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_step;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_fin_hi;
  logic [31:0] w_fin_lo;

  // Multiplier bits are consumed from the LSB of lo while the product shifts in from the top.
  function automatic logic [63:0] mul_step(input logic [31:0] hi_in, input logic [31:0] lo_in,
                                           input logic [31:0] mcand);
    logic [32:0] s;
    logic [31:0] h;
    logic [31:0] l;
    h = hi_in;
    l = lo_in;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      s = {1'b0, h} + (l[0] ? {1'b0, mcand} : 33'd0);
      l = {s[0], l[31:1]};
      h = s[32:1];
    end
    return {h, l};
  endfunction

  function automatic logic [63:0] div_step(input logic [31:0] rem_in, input logic [31:0] quo_in,
                                           input logic [31:0] dvs);
    logic [32:0] r;
    logic [32:0] t;
    logic [31:0] q;
    r = {1'b0, rem_in};
    q = quo_in;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      r = {r[31:0], q[31]};
      q = {q[30:0], 1'b0};
      t = r - {1'b0, dvs};
      if (!t[32]) begin
        r    = t;
        q[0] = 1'b1;
      end
    end
    return {r[31:0], q};
  endfunction

  assign w_op     = bus.instr[31:26];
  assign w_funct  = bus.instr[5:0];
  assign w_simm   = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign w_zimm   = {16'h0000, bus.instr[15:0]};
  assign w_accept = (r_state == S_IDLE) && bus.instr_valid;

  always_comb begin
    w_cls  = C_ILL;
    w_ctrl = 4'h0;
    w_b    = bus.rt_data;
    w_dest = bus.instr[15:11];
    w_wr   = 1'b0;
    w_sgn  = 1'b0;
    if (w_op == 6'h00) begin
      case (w_funct)
        6'h21: begin w_cls = C_ALU; w_ctrl = 4'h4; w_wr = 1'b1; end
        6'h23: begin w_cls = C_ALU; w_ctrl = 4'h5; w_wr = 1'b1; end
        6'h24: begin w_cls = C_ALU; w_ctrl = 4'h0; w_wr = 1'b1; end
        6'h25: begin w_cls = C_ALU; w_ctrl = 4'h1; w_wr = 1'b1; end
        6'h26: begin w_cls = C_ALU; w_ctrl = 4'h2; w_wr = 1'b1; end
        6'h2A: begin w_cls = C_ALU; w_ctrl = 4'hE; w_wr = 1'b1; end
        6'h2B: begin w_cls = C_ALU; w_ctrl = 4'h6; w_wr = 1'b1; end
        6'h00: begin w_cls = C_ALU; w_ctrl = 4'h8; w_wr = 1'b1; end
        6'h02: begin w_cls = C_ALU; w_ctrl = 4'h9; w_wr = 1'b1; end
        6'h03: begin w_cls = C_ALU; w_ctrl = 4'hC; w_wr = 1'b1; end
        6'h04: begin w_cls = C_ALU; w_ctrl = 4'hA; w_wr = 1'b1; end
        6'h06: begin w_cls = C_ALU; w_ctrl = 4'hB; w_wr = 1'b1; end
        6'h07: begin w_cls = C_ALU; w_ctrl = 4'hD; w_wr = 1'b1; end
        6'h08: begin w_cls = C_ALU; w_ctrl = 4'h7; end
        6'h10: begin w_cls = C_MFHI; w_wr = 1'b1; end
        6'h12: begin w_cls = C_MFLO; w_wr = 1'b1; end
        6'h11: w_cls = C_MTHI;
        6'h13: w_cls = C_MTLO;
        6'h18: begin w_cls = C_MUL; w_sgn = 1'b1; end
        6'h19: w_cls = C_MUL;
        6'h1A: begin w_cls = C_DIV; w_sgn = 1'b1; end
        6'h1B: w_cls = C_DIV;
        default: w_cls = C_ILL;
      endcase
    end else begin
      w_dest = bus.instr[20:16];
      w_cls  = C_ALU;
      w_wr   = 1'b1;
      case (w_op)
        6'h09: begin w_ctrl = 4'h4; w_b = w_simm; end
        6'h0A: begin w_ctrl = 4'hE; w_b = w_simm; end
        6'h0B: begin w_ctrl = 4'h6; w_b = w_simm; end
        6'h0C: begin w_ctrl = 4'h0; w_b = w_zimm; end
        6'h0D: begin w_ctrl = 4'h1; w_b = w_zimm; end
        6'h0E: begin w_ctrl = 4'h2; w_b = w_zimm; end
        6'h0F: begin w_ctrl = 4'h3; w_b = w_zimm; end
        default: begin w_cls = C_ILL; w_wr = 1'b0; end
      endcase
    end
  end

  assign w_we    = w_wr && (w_dest != 5'd0);
  assign w_neg_a = w_sgn && bus.rs_data[31];
  assign w_neg_b = w_sgn && bus.rt_data[31];
  assign w_mag_a = w_neg_a ? (~bus.rs_data + 32'd1) : bus.rs_data;
  assign w_mag_b = w_neg_b ? (~bus.rt_data + 32'd1) : bus.rt_data;

  assign w_step = (r_cls == C_MUL) ? mul_step(r_w_hi, r_w_lo, r_mcand)
                                   : div_step(r_w_hi, r_w_lo, r_mcand);
  assign w_prod = r_neg_q ? (~w_step + 64'd1) : w_step;
  assign w_quo  = r_neg_q ? (~w_step[31:0] + 32'd1) : w_step[31:0];
  assign w_rem  = r_neg_r ? (~w_step[63:32] + 32'd1) : w_step[63:32];

  // Division by zero reports all-ones quotient and returns the untouched dividend.
  always_comb begin
    w_fin_hi = w_rem;
    w_fin_lo = w_quo;
    if (r_cls == C_MUL) begin
      w_fin_hi = w_prod[63:32];
      w_fin_lo = w_prod[31:0];
    end else if (r_div0) begin
      w_fin_hi = r_opa;
      w_fin_lo = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 6'd0;
      r_cls         <= C_ALU;
      r_opa         <= 32'd0;
      r_w_hi        <= 32'd0;
      r_w_lo        <= 32'd0;
      r_mcand       <= 32'd0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_div0        <= 1'b0;
      r_alu_control <= 5'd0;
      r_alu_a       <= 32'd0;
      r_alu_b       <= 32'd0;
      r_alu_sa      <= 6'd0;
      r_result      <= 32'd0;
      r_dest        <= 5'd0;
      r_we          <= 1'b0;
      r_illegal     <= 1'b0;
      r_hi          <= 32'd0;
      r_lo          <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cls     <= w_cls;
            r_opa     <= bus.rs_data;
            r_dest    <= w_dest;
            r_we      <= w_we;
            r_illegal <= (w_cls == C_ILL);
            if (w_cls == C_ALU) begin
              r_alu_control <= {1'b0, w_ctrl};
              r_alu_a       <= bus.rs_data;
              r_alu_b       <= w_b;
              r_alu_sa      <= {1'b0, bus.instr[10:6]};
            end
            if (w_cls == C_MUL || w_cls == C_DIV) begin
              r_w_hi  <= 32'd0;
              r_w_lo  <= (w_cls == C_MUL) ? w_mag_b : w_mag_a;
              r_mcand <= (w_cls == C_MUL) ? w_mag_a : w_mag_b;
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
              r_div0  <= (bus.rt_data == 32'd0);
              r_cnt   <= ITER_M1;
              r_state <= S_MULDIV;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (r_cls == C_ALU) begin
            r_cnt   <= LAT_M1;
            r_state <= S_WAIT;
          end else begin
            r_result <= 32'd0;
            case (r_cls)
              C_MFHI:  r_result <= r_hi;
              C_MFLO:  r_result <= r_lo;
              C_MTHI:  r_hi     <= r_opa;
              C_MTLO:  r_lo     <= r_opa;
              default: ;
            endcase
            r_state <= S_DONE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 6'd0) begin
            r_result <= bus.alu_r;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_MULDIV: begin
          if (r_cnt == 6'd0) begin
            r_hi     <= w_fin_hi;
            r_lo     <= w_fin_lo;
            r_result <= 32'd0;
            r_state  <= S_DONE;
          end else begin
            r_w_hi <= w_step[63:32];
            r_w_lo <= w_step[31:0];
            r_cnt  <= r_cnt - 6'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready  = (r_state == S_IDLE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result_valid = (r_state == S_DONE);
  assign bus.alu_control  = r_alu_control;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_sa       = r_alu_sa;
  assign bus.result       = r_result;
  assign bus.dest_reg     = r_dest;
  assign bus.write_en     = r_we;
  assign bus.illegal      = r_illegal;
  assign bus.hi           = r_hi;
  assign bus.lo           = r_lo;

endmodule

// File: tb/tb_mips_cpu_alu_sequencer.sv
// Table-driven bench for the ALU sequencer with a registered ALU model and an expected-result queue.
module tb_mips_cpu_alu_sequencer;

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        chk_alu;
    logic [4:0]  ctrl;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  dest;
    logic        we;
    logic        ill;
    logic        chk_hl;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   n_acc;
  vec_t tbl[$];
  vec_t sb[$];

  mips_cpu_alu_sequencer_if sif();

  mips_cpu_alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sif.instr_valid && sif.instr_ready && !reset) n_acc <= n_acc + 1;
  end

  // Registered ALU: one cycle from operands to result.
  always @(posedge clk) begin
    if (reset) sif.alu_r <= 32'd0;
    else begin
      case (sif.alu_control[3:0])
        4'h0: sif.alu_r <= sif.alu_a & sif.alu_b;
        4'h1: sif.alu_r <= sif.alu_a | sif.alu_b;
        4'h2: sif.alu_r <= sif.alu_a ^ sif.alu_b;
        4'h3: sif.alu_r <= {sif.alu_b[15:0], 16'h0000};
        4'h4: sif.alu_r <= sif.alu_a + sif.alu_b;
        4'h5: sif.alu_r <= sif.alu_a - sif.alu_b;
        4'h6: sif.alu_r <= {31'd0, sif.alu_a < sif.alu_b};
        4'h7: sif.alu_r <= sif.alu_a;
        4'h8: sif.alu_r <= sif.alu_b << sif.alu_sa[4:0];
        4'h9: sif.alu_r <= sif.alu_b >> sif.alu_sa[4:0];
        4'hA: sif.alu_r <= sif.alu_b << sif.alu_a[4:0];
        4'hB: sif.alu_r <= sif.alu_b >> sif.alu_a[4:0];
        4'hC: sif.alu_r <= $signed(sif.alu_b) >>> sif.alu_sa[4:0];
        4'hD: sif.alu_r <= $signed(sif.alu_b) >>> sif.alu_a[4:0];
        4'hE: sif.alu_r <= {31'd0, $signed(sif.alu_a) < $signed(sif.alu_b)};
        default: sif.alu_r <= 32'd0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] sa, input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, rd, sa, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  task automatic add(input string nm, input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                     input logic chk_alu, input logic [4:0] ctrl, input logic [31:0] b, input logic [31:0] res,
                     input logic [4:0] dest, input logic we, input logic ill, input logic chk_hl,
                     input logic [31:0] hi, input logic [31:0] lo, input int lat);
    vec_t v;
    v.nm = nm; v.instr = instr; v.rs = rs; v.rt = rt; v.chk_alu = chk_alu; v.ctrl = ctrl; v.b = b;
    v.res = res; v.dest = dest; v.we = we; v.ill = ill; v.chk_hl = chk_hl; v.hi = hi; v.lo = lo;
    v.lat = lat; v.acc = 0;
    tbl.push_back(v);
  endtask

  // Retirement monitor: every result_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sif.result_valid) begin
      if (sb.size() == 0) chk("unexpected_result_valid", 32'd1, 32'd0);
      else begin
        vec_t e;
        e = sb.pop_front();
        chk({e.nm, "_result"}, sif.result, e.res);
        chk({e.nm, "_write_en"}, {31'd0, sif.write_en}, {31'd0, e.we});
        chk({e.nm, "_illegal"}, {31'd0, sif.illegal}, {31'd0, e.ill});
        chk({e.nm, "_latency"}, cyc - e.acc, e.lat);
        if (e.we) chk({e.nm, "_dest_reg"}, {27'd0, sif.dest_reg}, {27'd0, e.dest});
        if (e.chk_hl) begin
          chk({e.nm, "_hi"}, sif.hi, e.hi);
          chk({e.nm, "_lo"}, sif.lo, e.lo);
        end
      end
    end
  end

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!sif.instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send(input vec_t v);
    wait_ready(v.nm);
    v.acc = cyc + 1;
    sb.push_back(v);
    sif.instr_valid = 1'b1;
    sif.instr       = v.instr;
    sif.rs_data     = v.rs;
    sif.rt_data     = v.rt;
    @(posedge clk);
    #1 sif.instr_valid = 1'b0;
    @(negedge clk);
    if (v.chk_alu) begin
      chk({v.nm, "_alu_control"}, {27'd0, sif.alu_control}, {27'd0, v.ctrl});
      chk({v.nm, "_alu_a"}, sif.alu_a, v.rs);
      chk({v.nm, "_alu_b"}, sif.alu_b, v.b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int acc0;
    vec_t v;
    cyc = 0; n_chk = 0; n_fail = 0; n_acc = 0;
    reset = 1'b1;
    sif.instr_valid = 1'b0;
    sif.instr = 32'd0;
    sif.rs_data = 32'd0;
    sif.rt_data = 32'd0;

    add("addu",      enc_r(5'd3, 5'd0, 6'h21), 32'd7, 32'd5, 1, 5'h04, 32'd5, 32'd12, 5'd3, 1, 0, 0, 0, 0, 2);
    add("addiu_neg", enc_i(6'h09, 5'd4, 16'hFFFF), 32'd1, 32'd0, 1, 5'h04, 32'hFFFFFFFF, 32'd0, 5'd4, 1, 0, 0, 0, 0, 2);
    add("andi_zext", enc_i(6'h0C, 5'd6, 16'hFFFF), 32'h12345678, 32'd0, 1, 5'h00, 32'h0000FFFF, 32'h5678, 5'd6, 1, 0, 0, 0, 0, 2);
    add("subu",      enc_r(5'd2, 5'd0, 6'h23), 32'd5, 32'd7, 1, 5'h05, 32'd7, 32'hFFFFFFFE, 5'd2, 1, 0, 0, 0, 0, 2);
    add("slt",       enc_r(5'd1, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1, 1, 5'h0E, 32'd1, 32'd1, 5'd1, 1, 0, 0, 0, 0, 2);
    add("sltu",      enc_r(5'd1, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'd1, 1, 5'h06, 32'd1, 32'd0, 5'd1, 1, 0, 0, 0, 0, 2);
    add("sra",       enc_r(5'd5, 5'd4, 6'h03), 32'd0, 32'h80000000, 1, 5'h0C, 32'h80000000, 32'hF8000000, 5'd5, 1, 0, 0, 0, 0, 2);
    add("srlv",      enc_r(5'd7, 5'd0, 6'h06), 32'd4, 32'hF0, 1, 5'h0B, 32'hF0, 32'h0F, 5'd7, 1, 0, 0, 0, 0, 2);
    add("lui",       enc_i(6'h0F, 5'd8, 16'h1234), 32'd0, 32'd0, 1, 5'h03, 32'h1234, 32'h12340000, 5'd8, 1, 0, 0, 0, 0, 2);
    add("xori",      enc_i(6'h0E, 5'd9, 16'h0F0F), 32'hFF, 32'd0, 1, 5'h02, 32'h0F0F, 32'h0FF0, 5'd9, 1, 0, 0, 0, 0, 2);
    add("addu_r0",   enc_r(5'd0, 5'd0, 6'h21), 32'd1, 32'd2, 1, 5'h04, 32'd2, 32'd3, 5'd0, 0, 0, 0, 0, 0, 2);
    add("jr",        enc_r(5'd0, 5'd0, 6'h08), 32'h400, 32'd0, 1, 5'h07, 32'd0, 32'h400, 5'd0, 0, 0, 0, 0, 0, 2);
    add("mthi",      enc_r(5'd0, 5'd0, 6'h11), 32'h1234, 32'd0, 0, 0, 0, 32'd0, 5'd0, 0, 0, 1, 32'h1234, 32'd0, 1);
    add("mfhi",      enc_r(5'd9, 5'd0, 6'h10), 32'd0, 32'd0, 0, 0, 0, 32'h1234, 5'd9, 1, 0, 0, 0, 0, 1);
    add("mtlo",      enc_r(5'd0, 5'd0, 6'h13), 32'hABCD, 32'd0, 0, 0, 0, 32'd0, 5'd0, 0, 0, 1, 32'h1234, 32'hABCD, 1);
    add("mflo",      enc_r(5'd10, 5'd0, 6'h12), 32'd0, 32'd0, 0, 0, 0, 32'hABCD, 5'd10, 1, 0, 0, 0, 0, 1);
    add("mult",      enc_r(5'd0, 5'd0, 6'h18), 32'hFFFFFFFE, 32'd3, 0, 0, 0, 32'd0, 5'd0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 32);
    add("multu",     enc_r(5'd0, 5'd0, 6'h19), 32'hFFFFFFFE, 32'd3, 0, 0, 0, 32'd0, 5'd0, 0, 0, 1, 32'h00000002, 32'hFFFFFFFA, 32);
    add("div",       enc_r(5'd0, 5'd0, 6'h1A), 32'hFFFFFFF9, 32'd2, 0, 0, 0, 32'd0, 5'd0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 32);
    add("divu_zero", enc_r(5'd0, 5'd0, 6'h1B), 32'd5, 32'd0, 0, 0, 0, 32'd0, 5'd0, 0, 0, 1, 32'h00000005, 32'hFFFFFFFF, 32);
    add("div_ovf",   enc_r(5'd0, 5'd0, 6'h1A), 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 32'd0, 5'd0, 0, 0, 1, 32'd0, 32'h80000000, 32);
    add("ill_funct", enc_r(5'd4, 5'd0, 6'h3F), 32'd9, 32'd9, 0, 0, 0, 32'd0, 5'd0, 0, 1, 1, 32'd0, 32'h80000000, 1);
    add("ill_op",    {6'h3F, 26'h0}, 32'd9, 32'd9, 0, 0, 0, 32'd0, 5'd0, 0, 1, 1, 32'd0, 32'h80000000, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_ready", {31'd0, sif.instr_ready}, 32'd1);
    chk("rst_busy", {31'd0, sif.busy}, 32'd0);
    chk("rst_result_valid", {31'd0, sif.result_valid}, 32'd0);
    chk("rst_hi", sif.hi, 32'd0);
    chk("rst_lo", sif.lo, 32'd0);
    chk("rst_alu_control", {27'd0, sif.alu_control}, 32'd0);
    reset = 1'b0;

    // Reset during the tenth iteration of a divide: no retirement, HI/LO stay cleared.
    wait_ready("rst_div");
    sif.instr_valid = 1'b1;
    sif.instr       = enc_r(5'd0, 5'd0, 6'h1A);
    sif.rs_data     = 32'hFFFFFFF9;
    sif.rt_data     = 32'd2;
    @(posedge clk);
    #1 sif.instr_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("rst_div_busy", {31'd0, sif.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_div_hi", sif.hi, 32'd0);
    chk("rst_div_lo", sif.lo, 32'd0);
    chk("rst_div_ready", {31'd0, sif.instr_ready}, 32'd1);
    repeat (40) @(negedge clk);
    chk("rst_div_hi_later", sif.hi, 32'd0);

    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);

    // Valid held high across several transactions: one transfer per IDLE visit.
    wait_ready("b2b");
    acc0 = n_acc;
    for (int k = 0; k < 3; k++) begin
      v = tbl[0];
      v.nm  = "b2b";
      v.acc = cyc + 1 + 4 * k;
      sb.push_back(v);
    end
    sif.instr_valid = 1'b1;
    sif.instr       = tbl[0].instr;
    sif.rs_data     = 32'd7;
    sif.rt_data     = 32'd5;
    repeat (9) @(posedge clk);
    #1 sif.instr_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", sb.size(), 32'd0);
    chk("b2b_transfers", n_acc - acc0, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
